axi4_burst_slave_mem: RTL

AXI4 (full) memory-mapped slave responder with a small on-chip word memory. It answers burst writes and burst reads from an AXI4 master, such as the M00_AXI burst initiator of the mask32 IP. It is the loopback target for master-side bring-up and for standalone simulation of DMA/FFT data movers. Write and read channels run as independent state machines sharing one dual-port word array.

---
 rtl/axi4_burst_slave_mem.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 burst slave with on-chip word memory.
// Independent write and read FSMs share one dual-port array.
module axi4_burst_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << AW;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int NB    = DW / 8;

  typedef logic [AW-1:0]           waddr_t;
  typedef logic [C_S_AXI_ID_WIDTH-1:0] id_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  function automatic logic burst_bad(
    input logic [1:0] burst,
    input logic [7:0] len,
    input logic [2:0] size
  );
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    return (size != 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !wrap_ok);
  endfunction

  // WRAP keeps the upper bits and increments inside the LEN+1 window
  function automatic waddr_t next_addr(
    input waddr_t     a,
    input logic [1:0] burst,
    input logic [7:0] len
  );
    waddr_t mask;
    waddr_t inc;
    mask = waddr_t'(len[3:0]);
    inc  = a + waddr_t'(1);
    unique case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  logic [DW-1:0] mem [DEPTH];

  w_state_e   w_state_q, w_state_d;
  id_t        wid_q, wid_d;
  waddr_t     waddr_q, waddr_d;
  logic [7:0] wlen_q, wlen_d;
  logic [1:0] wburst_q, wburst_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       werr_q, werr_d;
  logic       wlerr_q, wlerr_d;
  logic       awready_q, awready_d;
  logic       mem_we;

  r_state_e   r_state_q, r_state_d;
  id_t        rid_q, rid_d;
  waddr_t     raddr_q, raddr_d;
  logic [7:0] rlen_q, rlen_d;
  logic [1:0] rburst_q, rburst_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic       rerr_q, rerr_d;
  logic       arready_q, arready_d;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0],
                             S_AXI_ARADDR[1:0]};

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    wlerr_d   = wlerr_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (awready_q && S_AXI_AWVALID) begin
          wid_d     = S_AXI_AWID;
          waddr_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          wlen_d    = S_AXI_AWLEN;
          wburst_d  = S_AXI_AWBURST;
          wcnt_d    = 8'd0;
          werr_d    = burst_bad(S_AXI_AWBURST,
                                S_AXI_AWLEN,
                                S_AXI_AWSIZE);
          wlerr_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID) begin
          mem_we  = !werr_q;
          waddr_d = next_addr(waddr_q, wburst_q, wlen_q);
          wcnt_d  = wcnt_q + 8'd1;
          if (S_AXI_WLAST != (wcnt_q == wlen_q))
            wlerr_d = 1'b1;
          if (wcnt_q == wlen_q)
            w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY)
          w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      wlerr_q   <= 1'b0;
      awready_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      wlerr_q   <= wlerr_d;
      awready_q <= awready_d;
    end
  end

  // Contents survive reset by design
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b])
          mem[waddr_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = (w_state_q == W_DATA);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BID     = wid_q;
  assign S_AXI_BRESP   = (S_AXI_BVALID && (werr_q || wlerr_q)) ?
                         2'b10 : 2'b00;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arready_q && S_AXI_ARVALID) begin
          rid_d     = S_AXI_ARID;
          raddr_d   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
          rlen_d    = S_AXI_ARLEN;
          rburst_d  = S_AXI_ARBURST;
          rcnt_d    = 8'd0;
          rerr_d    = burst_bad(S_AXI_ARBURST,
                                S_AXI_ARLEN,
                                S_AXI_ARSIZE);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          if (rcnt_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d = next_addr(raddr_q, rburst_q, rlen_q);
            rcnt_d  = rcnt_q + 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      arready_q <= arready_d;
    end
  end

  // Array read is asynchronous, so a same-cycle write shows up next cycle
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RLAST   = S_AXI_RVALID && (rcnt_q == rlen_q);
  assign S_AXI_RRESP   = (S_AXI_RVALID && rerr_q) ? 2'b10 : 2'b00;
  assign S_AXI_RDATA   = (S_AXI_RVALID && !rerr_q) ?
                         mem[raddr_q] : '0;

endmodule
